reg_file_shadow_cfg: RTL
========================

# reg_file_shadow_cfg

Parametrised register file with staged (shadow) configuration registers, atomic commit, a sticky write-lock and registered reads with a valid pulse. It is the next-generation configuration store between the system controller and the configurable peripherals (UART, clock divider, ALU operands). Configuration outputs change only on an explicit commit, so all consumers see one coherent configuration update.

## Interface
- ADDRESS_WIDTH, 4, address bits; DEPTH = 2**ADDRESS_WIDTH entries
- DATA_WIDTH, 8, entry width (≥2)
- NUM_CFG, 4, shadowed config entries at addresses 0..NUM_CFG-1; legal range 1..DEPTH-2
- RST_VECTOR, {8'h08, 8'h20, 8'h00, 8'h00}, NUM_CFG*DATA_WIDTH reset values; entry i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- CLK  in  1  clock; one clock domain
- RST  in  1  synchronous, active-high reset
- WrEn  in  1  write request
- RdEn  in  1  read request
- Address  in  ADDRESS_WIDTH  access address
- WrData  in  DATA_WIDTH  write data
- RdData  out  DATA_WIDTH  registered read data
- RdData_Valid  out  1  one-cycle pulse with each read result
- CFG  out  NUM_CFG*DATA_WIDTH  active (committed) config, same packing as RST_VECTOR
- CFG_Update  out  1  one-cycle pulse when CFG takes new committed values
- Wr_Err  out  1  one-cycle pulse on a rejected access
- Par_Err  out  1  only with REG_FILE_PARITY_EN; see Configuration

## Operation
- Address map: 0..NUM_CFG-1 shadow config; NUM_CFG..DEPTH-2 general purpose; DEPTH-1 control/status (CTRL).
- Access decode per cycle: WrEn&!RdEn = write; RdEn&!WrEn = read; both high = rejected (Wr_Err pulse, no state change); neither = idle.
- Write to shadow address: shadow entry updated, pending flag set, CFG unchanged.
- Write to general address: entry updated.
- Write to CTRL: WrData[0]=1 commits (all active entries <= shadow, pending cleared, CFG_Update pulse); WrData[1]=1 sets lock. Both bits in one write: commit completes, lock is set by the same edge. Other bits ignored; nothing stored.
- Locked (sticky until RST): writes to shadow addresses and to CTRL are rejected (Wr_Err pulse, no change); general-purpose writes and all reads still work.
- Commit with pending=0 is still a commit: CFG rewritten with identical values, CFG_Update pulses.
- Read: shadow address returns shadow (not active) value; general returns entry; CTRL returns {zeros, lock, pending} (bit1 lock, bit0 pending).
- RdData holds last read value between reads; writes never disturb it.

## Timing
- Reset (RST high at edge): shadow and active = RST_VECTOR; general entries 0; lock 0; pending 0; RdData 0; RdData_Valid 0; CFG_Update 0; Wr_Err 0; Par_Err 0. RST overrides any same-cycle access.
- Write: request at edge N, storage updated at edge N; read issued at cycle N+1 returns new data.
- Read: request at edge N; RdData and RdData_Valid=1 valid after edge N (one-cycle latency); back-to-back reads give one valid pulse each.
- Commit at edge N: CFG and CFG_Update=1 both change at edge N; CFG_Update low after edge N+1 unless another commit.
- Wr_Err: registered, high for the cycle after the rejecting edge.
- No backpressure; every cycle accepts a new access.

## Configuration
- REG_FILE_PARITY_EN defined: every general, shadow and active entry stores an even-parity bit generated on write/reset/commit; reads recompute it; mismatch drives Par_Err=1 with the same RdData_Valid pulse. Active entries are checked continuously; mismatch pulses Par_Err one cycle.
- Undefined: no parity storage, no Par_Err port.

## Structure
- Package reg_file_pkg: CTRL_COMMIT_BIT=0, CTRL_LOCK_BIT=1, STAT_PENDING_BIT=0, STAT_LOCK_BIT=1, default RST_VECTOR constant.
- Sub-module reg_file_parity (parity generate/check, DATA_WIDTH parameter), instantiated only under REG_FILE_PARITY_EN.

## Test plan
- Reset then read addr 2, 3 -> RdData 8'h20, 8'h08 one cycle later, RdData_Valid single pulse; CFG = {08,20,00,00}.
- Write 8'h5A to addr 1, read addr 1 -> 8'h5A; CFG entry 1 stays 8'h00; read CTRL (addr 15) -> 8'h01.
- Write CTRL 8'h01 -> CFG entry 1 = 8'h5A and CFG_Update=1 same edge; next CTRL read -> 8'h00.
- Write CTRL 8'h03, then write 8'hFF to addr 0 -> Wr_Err pulse, addr 0 reads old value; write 8'h77 to addr 6 succeeds; CTRL reads 8'h02.
- WrEn and RdEn both high on addr 4 -> Wr_Err pulse, no RdData_Valid, addr 4 unchanged.
- Assert RST while locked with pending writes -> all outputs return to reset values, lock cleared, addr 0 write accepted.

Source files
------------

// File: rtl/reg_file_shadow_cfg_pkg.sv
// reg_file_pkg: shared constants, access decode type and the parity helper
// for reg_file_shadow_cfg.
`default_nettype none

package reg_file_pkg;

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_LOCK_BIT    = 1;
    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_LOCK_BIT    = 1;

    localparam logic [31:0] DEFAULT_RST_VECTOR = {8'h08, 8'h20, 8'h00, 8'h00};

    typedef enum logic [1:0] {
        ACC_IDLE     = 2'd0,
        ACC_WRITE    = 2'd1,
        ACC_READ     = 2'd2,
        ACC_CONFLICT = 2'd3
    } access_e;

    // Even parity over a zero-extended entry; extra zero bits do not change it.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_shadow_cfg_if.sv
// Access bus between the system controller and reg_file_shadow_cfg.
// Par_Err exists only when REG_FILE_PARITY_EN is defined.
`default_nettype none

interface reg_file_shadow_cfg_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) ();

    logic                     WrEn;
    logic                     RdEn;
    logic [ADDRESS_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]    WrData;
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic                     Wr_Err;
`ifdef REG_FILE_PARITY_EN
    logic                     Par_Err;

    modport master (output WrEn, RdEn, Address, WrData,
                    input  RdData, RdData_Valid, Wr_Err, Par_Err);
    modport slave  (input  WrEn, RdEn, Address, WrData,
                    output RdData, RdData_Valid, Wr_Err, Par_Err);
`else
    modport master (output WrEn, RdEn, Address, WrData,
                    input  RdData, RdData_Valid, Wr_Err);
    modport slave  (input  WrEn, RdEn, Address, WrData,
                    output RdData, RdData_Valid, Wr_Err);
`endif

endinterface

`default_nettype wire

// File: rtl/reg_file_shadow_cfg_parity.sv
// reg_file_parity: recomputes even parity of an entry and flags a mismatch
// against its stored parity bit. Used only with REG_FILE_PARITY_EN.
`default_nettype none

module reg_file_parity #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  par_i,
    output logic                       err_o
);

    assign err_o = (^data_i) ^ par_i;

endmodule

`default_nettype wire

// File: rtl/reg_file_shadow_cfg.sv
// reg_file_shadow_cfg: register file with shadowed config entries, atomic
// commit, sticky lock and registered reads. Optional parity: REG_FILE_PARITY_EN.
`default_nettype none

module reg_file_shadow_cfg
    import reg_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CFG       = 4,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] RST_VECTOR = DEFAULT_RST_VECTOR
) (
    input  wire logic                          CLK,
    input  wire logic                          RST,
    reg_file_shadow_cfg_if.slave               bus,
    output logic [NUM_CFG*DATA_WIDTH-1:0]      CFG,
    output logic                               CFG_Update
);

    localparam int DEPTH   = 2 ** ADDRESS_WIDTH;
    localparam int NUM_GEN = DEPTH - 1 - NUM_CFG;

    logic [DATA_WIDTH-1:0] shadow_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] active_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] gen_q    [NUM_GEN];
    logic                  lock_q;
    logic                  pending_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rvalid_q;
    logic                  werr_q;
    logic                  upd_q;

    access_e acc;
    logic    sel_cfg;
    logic    sel_ctrl;
    logic    wr_ok;
    logic    reject;
    logic    commit;
    logic    lock_set;
    logic    wr_cfg;
    logic    wr_gen;

    always_comb begin
        unique case ({bus.RdEn, bus.WrEn})
            2'b01:   acc = ACC_WRITE;
            2'b10:   acc = ACC_READ;
            2'b11:   acc = ACC_CONFLICT;
            default: acc = ACC_IDLE;
        endcase
    end

    assign sel_cfg  = bus.Address < ADDRESS_WIDTH'(NUM_CFG);
    assign sel_ctrl = bus.Address == ADDRESS_WIDTH'(DEPTH - 1);
    // Lock protects the shadow entries and CTRL itself, so it cannot be cleared.
    assign wr_ok    = (acc == ACC_WRITE) && !(lock_q && (sel_cfg || sel_ctrl));
    assign reject   = (acc == ACC_CONFLICT) || ((acc == ACC_WRITE) && !wr_ok);
    assign commit   = wr_ok && sel_ctrl && bus.WrData[CTRL_COMMIT_BIT];
    assign lock_set = wr_ok && sel_ctrl && bus.WrData[CTRL_LOCK_BIT];
    assign wr_cfg   = wr_ok && sel_cfg;
    assign wr_gen   = wr_ok && !sel_cfg && !sel_ctrl;

    always_comb begin
        rdata_d = '0;
        if (sel_ctrl) begin
            rdata_d[STAT_LOCK_BIT]    = lock_q;
            rdata_d[STAT_PENDING_BIT] = pending_q;
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (bus.Address == ADDRESS_WIDTH'(i)) rdata_d = shadow_q[i];
        end
        for (int j = 0; j < NUM_GEN; j++) begin
            if (bus.Address == ADDRESS_WIDTH'(NUM_CFG + j)) rdata_d = gen_q[j];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_q[i] <= RST_VECTOR[i*DATA_WIDTH +: DATA_WIDTH];
                active_q[i] <= RST_VECTOR[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int j = 0; j < NUM_GEN; j++) gen_q[j] <= '0;
            lock_q    <= 1'b0;
            pending_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            werr_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            rvalid_q <= (acc == ACC_READ);
            werr_q   <= reject;
            upd_q    <= commit;
            if (acc == ACC_READ) rdata_q <= rdata_d;
            if (commit) begin
                for (int i = 0; i < NUM_CFG; i++) active_q[i] <= shadow_q[i];
                pending_q <= 1'b0;
            end
            if (lock_set) lock_q <= 1'b1;
            if (wr_cfg) begin
                pending_q <= 1'b1;
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (bus.Address == ADDRESS_WIDTH'(i)) shadow_q[i] <= bus.WrData;
                end
            end
            if (wr_gen) begin
                for (int j = 0; j < NUM_GEN; j++) begin
                    if (bus.Address == ADDRESS_WIDTH'(NUM_CFG + j)) gen_q[j] <= bus.WrData;
                end
            end
        end
    end

    always_comb begin
        CFG = '0;
        for (int i = 0; i < NUM_CFG; i++) CFG[i*DATA_WIDTH +: DATA_WIDTH] = active_q[i];
    end

    assign bus.RdData       = rdata_q;
    assign bus.RdData_Valid = rvalid_q;
    assign bus.Wr_Err       = werr_q;
    assign CFG_Update       = upd_q;

`ifdef REG_FILE_PARITY_EN
    logic               shadow_par_q [NUM_CFG];
    logic               active_par_q [NUM_CFG];
    logic               gen_par_q    [NUM_GEN];
    logic               rpar_d;
    logic               rd_err;
    logic [NUM_CFG-1:0] act_err;
    logic               perr_q;
    logic               wpar;

    assign wpar = even_parity(64'(bus.WrData));

    always_comb begin
        rpar_d = lock_q ^ pending_q;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (bus.Address == ADDRESS_WIDTH'(i)) rpar_d = shadow_par_q[i];
        end
        for (int j = 0; j < NUM_GEN; j++) begin
            if (bus.Address == ADDRESS_WIDTH'(NUM_CFG + j)) rpar_d = gen_par_q[j];
        end
    end

    reg_file_parity #(.DATA_WIDTH(DATA_WIDTH)) u_rd_par (
        .data_i (rdata_d),
        .par_i  (rpar_d),
        .err_o  (rd_err)
    );

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_act_par
        reg_file_parity #(.DATA_WIDTH(DATA_WIDTH)) u_act_par (
            .data_i (active_q[g]),
            .par_i  (active_par_q[g]),
            .err_o  (act_err[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_par_q[i] <= even_parity(64'(RST_VECTOR[i*DATA_WIDTH +: DATA_WIDTH]));
                active_par_q[i] <= even_parity(64'(RST_VECTOR[i*DATA_WIDTH +: DATA_WIDTH]));
            end
            for (int j = 0; j < NUM_GEN; j++) gen_par_q[j] <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            perr_q <= ((acc == ACC_READ) && rd_err) || (|act_err);
            if (commit) begin
                for (int i = 0; i < NUM_CFG; i++) active_par_q[i] <= shadow_par_q[i];
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg && bus.Address == ADDRESS_WIDTH'(i)) shadow_par_q[i] <= wpar;
            end
            for (int j = 0; j < NUM_GEN; j++) begin
                if (wr_gen && bus.Address == ADDRESS_WIDTH'(NUM_CFG + j)) gen_par_q[j] <= wpar;
            end
        end
    end

    assign bus.Par_Err = perr_q;
`endif

endmodule

`default_nettype wire
